// File: rtl/xbar_sched.sv
// Purpose : round-robin scheduler sharing one xbar among NREQ requesters over a toggle handshake.
// Latency : grant -> rsp_valid = 1 issue + xbar delay + 2 sync + 1 capture cycles.
// Backpressure: one job in flight; RESP holds rsp_* until rsp_ready, no grants while busy.
// Optional watchdog: define XBAR_SCHED_TIMEOUT_EN to bound WAIT at TIMEOUT cycles (rsp_err=1).
module xbar_sched #(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 1024,
  parameter  int QW      = 32,
  parameter  int XH      = 4,
  parameter  int XW      = 4,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][XH-1:0][QW-1:0]  req_vec,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [IW-1:0]                    rsp_id,
  output logic [XW-1:0][QW-1:0]            rsp_vec,
  output logic                             rsp_err,
  output logic [XH-1:0][QW-1:0]            xb_vec_o,
  input  logic [XW-1:0][QW-1:0]            xb_vec_i,
  output logic                             xb_valid_tg,
  input  logic                             xb_ready_tg,
  output logic                             busy
);

  // Elaboration-time guard on parameters that would break the rr arithmetic or the counter.
  if (NREQ < 2 || TIMEOUT < 1 || TIMEOUT > 65536) begin : g_bad_params
    $error("xbar_sched: need NREQ >= 2 and 1 <= TIMEOUT <= 65536");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                    r_state;
  logic [IW-1:0]             r_rr;
  logic                      r_sync1;
  logic                      r_rdy_s;
  logic                      r_valid_tg;
  logic [XH-1:0][QW-1:0]     r_xb_vec;
  logic [IW-1:0]             r_rsp_id;
  logic [XW-1:0][QW-1:0]     r_rsp_vec;
  logic                      r_rsp_valid;
  logic                      r_busy;
`ifdef XBAR_SCHED_TIMEOUT_EN
  logic                      r_rsp_err;
  logic [15:0]               r_cnt;
`endif

  logic                      w_quiet;
  logic                      w_gnt_any;
  logic [IW-1:0]             w_gnt_idx;
  logic [IW-1:0]             w_cand;
  logic                      w_fire;
  logic [IW-1:0]             w_rr_next;

  // The xbar has no job outstanding when its completion toggle has caught up with ours.
  assign w_quiet = (r_rdy_s == r_valid_tg);

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IW'((int'(r_rr) + k) % NREQ);
      if (!w_gnt_any && req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // A grant needs an idle FSM, a requester and a quiescent xbar (blocks stale completions).
  assign w_fire    = (r_state == S_IDLE) && w_gnt_any && w_quiet && !rst;
  assign w_rr_next = (w_gnt_idx == IW'(NREQ - 1)) ? '0 : (w_gnt_idx + IW'(1));

  // One-hot accept strobe, high only in the grant cycle.
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k] = w_fire && (w_gnt_idx == IW'(k));
    end
  end

  // Two-flop synchroniser for the asynchronous completion toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_rdy_s <= 1'b0;
    end else begin
      r_sync1 <= xb_ready_tg;
      r_rdy_s <= r_sync1;
    end
  end

  // Scheduler FSM with registered outputs: IDLE grants, WAIT tracks the xbar, RESP holds result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_valid_tg  <= 1'b0;
      r_xb_vec    <= '0;
      r_rsp_id    <= '0;
      r_rsp_vec   <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef XBAR_SCHED_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_xb_vec   <= req_vec[w_gnt_idx];
            r_rsp_id   <= w_gnt_idx;
            r_valid_tg <= ~r_valid_tg;
            r_rr       <= w_rr_next;
            r_busy     <= 1'b1;
            r_state    <= S_WAIT;
`ifdef XBAR_SCHED_TIMEOUT_EN
            r_cnt      <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (r_rdy_s == r_valid_tg) begin
            r_rsp_vec   <= xb_vec_i;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
`ifdef XBAR_SCHED_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_cnt == 16'(TIMEOUT - 1)) begin
            // Give up on the xbar; its late toggle is later absorbed by the IDLE gate.
            r_rsp_vec   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt       <= r_cnt + 16'd1;
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign xb_vec_o    = r_xb_vec;
  assign xb_valid_tg = r_valid_tg;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_vec     = r_rsp_vec;
  assign busy        = r_busy;
`ifdef XBAR_SCHED_TIMEOUT_EN
  assign rsp_err     = r_rsp_err;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_xbar_sched.sv
// Purpose : directed + randomized bench for xbar_sched with an event-driven xbar model.
// Latency : expects rsp_valid exactly xbar delay + 4 cycles after the grant cycle.
// Backpressure: exercises held rsp_ready, busy-time arrivals, drops, reset mid-job.
module tb_xbar_sched;
  localparam int NREQ = 4;
  localparam int QW   = 32;
  localparam int XH   = 4;
  localparam int XW   = 4;
  localparam int IW   = 2;
`ifdef XBAR_SCHED_TIMEOUT_EN
  localparam int TMO  = 16;
`else
  localparam int TMO  = 1024;
`endif

  typedef logic [XH-1:0][QW-1:0] ivec_t;
  typedef logic [XW-1:0][QW-1:0] ovec_t;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0]                 req_ready;
  logic [NREQ-1:0][XH-1:0][QW-1:0] req_vec;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [IW-1:0]                   rsp_id;
  ovec_t                           rsp_vec;
  logic                            rsp_err;
  ivec_t                           xb_vec_o;
  ovec_t                           xb_vec_i;
  logic                            xb_valid_tg;
  logic                            xb_ready_tg;
  logic                            busy;

  xbar_sched #(.NREQ(NREQ), .TIMEOUT(TMO), .QW(QW), .XH(XH), .XW(XW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_vec(rsp_vec),
    .rsp_err(rsp_err), .xb_vec_o(xb_vec_o), .xb_vec_i(xb_vec_i), .xb_valid_tg(xb_valid_tg),
    .xb_ready_tg(xb_ready_tg), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;
  int m_rr  = 0;

  // Xbar result: out[j] = sum_i in[i] * (i*XW + j + 1), modulo 2^QW.
  function automatic ovec_t wsum(ivec_t v);
    ovec_t r;
    for (int j = 0; j < XW; j++) begin
      r[j] = '0;
      for (int i = 0; i < XH; i++) r[j] = r[j] + v[i] * QW'(i * XW + j + 1);
    end
    return r;
  endfunction

  // Reference arbiter: first valid requester at or after rr, wrapping.
  function automatic int pick(int rr, logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (rr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Xbar model: every valid toggle schedules one completion toggle xb_delay cycles later.
  bit    xb_en    = 1'b1;
  int    xb_delay = 10;
  int    due_q[$];
  ovec_t res_q[$];
  logic  prev_vtg = 1'b0;
  int    n_tog    = 0;
  initial begin
    xb_ready_tg = 1'b0;
    xb_vec_i    = '0;
  end
  always @(negedge clk) begin
    if (!$isunknown(xb_valid_tg) && xb_valid_tg !== prev_vtg) begin
      prev_vtg = xb_valid_tg;
      n_tog++;
      if (xb_en) begin
        due_q.push_back(cyc + xb_delay);
        res_q.push_back(wsum(xb_vec_o));
      end
    end
    if (due_q.size() != 0 && cyc >= due_q[0]) begin
      void'(due_q.pop_front());
      xb_vec_i    = res_q.pop_front();
      xb_ready_tg = ~xb_ready_tg;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_grant(output int g, output bit ok);
    ok = 1'b0;
    g  = -1;
    for (int t = 0; t < 3000; t++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("grant_seen", 128'(ok), 128'(1));
    for (int k = NREQ - 1; k >= 0; k--) if (req_ready[k]) g = k;
  endtask

  // One job end to end; optional mid-job request-mask changes at WAIT cycles ma_t / mb_t.
  task automatic run_job(input bit drop, input int hold, input int ma_t, input logic [NREQ-1:0] ma_m,
                         input int mb_t, input logic [NREQ-1:0] mb_m, output int g);
    int    exp_g, lat, d;
    bit    ok;
    ivec_t v;
    ovec_t ev;
    wait_grant(g, ok);
    if (!ok) return;
    exp_g = pick(m_rr, req_valid);
    chk("grant_id", 128'(g), 128'(exp_g));
    if (exp_g < 0) exp_g = g;
    chk("grant_onehot", 128'(req_ready), 128'(NREQ'(1) << exp_g));
    chk("grant_xbar_idle", 128'(due_q.size()), 128'(0));
    chk("grant_quiet", 128'(xb_ready_tg), 128'(xb_valid_tg));
    v    = req_vec[exp_g];
    ev   = wsum(v);
    d    = xb_delay;
    m_rr = (exp_g + 1) % NREQ;
    @(posedge clk);
    #1;
    if (drop) req_valid[exp_g] = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("ready_one_cycle", 128'(req_ready), 128'(0));
        chk("xb_vec_issue", 128'(xb_vec_o), 128'(v));
        chk("busy_in_job", 128'(busy), 128'(1));
      end
      if (lat == ma_t) req_valid = ma_m;
      if (lat == mb_t) req_valid = mb_m;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rsp_seen", 128'(ok), 128'(1));
    chk("rsp_latency", 128'(lat), 128'(d + 4));
    chk("rsp_id", 128'(rsp_id), 128'(exp_g));
    chk("rsp_vec", 128'(rsp_vec), 128'(ev));
    chk("rsp_err", 128'(rsp_err), 128'(0));
    chk("xb_vec_stable", 128'(xb_vec_o), 128'(v));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 128'(rsp_valid), 128'(1));
      chk("hold_id", 128'(rsp_id), 128'(exp_g));
      chk("hold_vec", 128'(rsp_vec), 128'(ev));
      chk("hold_no_grant", 128'(req_ready), 128'(0));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_accept", 128'(rsp_valid), 128'(0));
    chk("idle_after", 128'(busy), 128'(0));
  endtask

  initial begin
    int g, n0;
    bit ok;
    int t2_ord[5];
    t2_ord = '{1, 2, 3, 0, 1};

    // Reset state, with a request pending to show reset suppresses the strobe.
    rst = 1'b1; req_valid = 4'b0001; rsp_ready = 1'b0; req_vec = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid_tg", 128'(xb_valid_tg), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_xb_vec", 128'(xb_vec_o), 128'(0));
    chk("rst_rsp", 128'({rsp_id, rsp_err}), 128'(0));
    rst = 1'b0; req_valid = '0;
    @(negedge clk);

    // T1: single request, constant vector, 40-cycle xbar.
    for (int i = 0; i < XH; i++) req_vec[0][i] = 32'h3F00_0000;
    xb_delay = 40;
    chk("t1_tg_before", 128'(xb_valid_tg), 128'(0));
    req_valid = 4'b0001;
    run_job(1'b1, 0, -1, '0, -1, '0, g);
    chk("t1_tg_after", 128'(xb_valid_tg), 128'(1));

    // T2: all four held valid; rr order from pointer 1, one toggle per job.
    n0 = n_tog;
    for (int k = 0; k < NREQ; k++) for (int i = 0; i < XH; i++) req_vec[k][i] = $urandom;
    xb_delay = 5;
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      run_job(1'b0, 0, -1, '0, -1, '0, g);
      chk("t2_order", 128'(g), 128'(t2_ord[j]));
    end
    req_valid = '0;
    chk("t2_toggles", 128'(n_tog - n0), 128'(5));

    // T3: response held 20 cycles with another requester waiting.
    xb_delay = 7;
    req_valid = 4'b0101;
    run_job(1'b1, 20, -1, '0, -1, '0, g);
    run_job(1'b1, 0, -1, '0, -1, '0, g);

    // Randomized jobs: masks, vectors, delays, backpressure and drops.
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < NREQ; k++) for (int i = 0; i < XH; i++) req_vec[k][i] = $urandom;
      xb_delay  = $urandom_range(1, 20);
      req_valid = NREQ'($urandom_range(1, 15));
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, 3), -1, '0, -1, '0, g);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    // T4: reset after the xbar completed but before capture; stale toggles must be absorbed.
    xb_delay = 3;
    for (int i = 0; i < XH; i++) req_vec[0][i] = 32'h0BAD_0000 + i;
    req_valid = 4'b0001;
    wait_grant(g, ok);
    chk("t4_grant", 128'(g), 128'(pick(m_rr, req_valid)));
    @(posedge clk);
    #1;
    req_valid = '0;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      #1;
      if (xb_ready_tg === xb_valid_tg) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4_xbar_done", 128'(ok), 128'(1));
    xb_delay = 30;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t4_rst_tg", 128'(xb_valid_tg), 128'(0));
    chk("t4_rst_out", 128'({rsp_valid, busy, req_ready}), 128'(0));
    chk("t4_rst_data", 128'({rsp_vec, rsp_id, rsp_err}), 128'(0));
    chk("t4_rst_xb_vec", 128'(xb_vec_o), 128'(0));
    rst = 1'b0;
    m_rr = 0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < NREQ; k++) for (int i = 0; i < XH; i++) req_vec[k][i] = $urandom;
    req_valid = 4'b0110;
    run_job(1'b1, 0, 2, 4'b0000, -1, '0, g);
    chk("t4_new_id", 128'(g), 128'(1));

    // T6: req1 and req2 arrive while busy, req2 drops before the grant; req1 must win.
    n0 = n_tog;
    xb_delay = 20;
    req_valid = 4'b0010;
    run_job(1'b1, 0, 5, 4'b0110, 10, 4'b0010, g);
    run_job(1'b1, 0, -1, '0, -1, '0, g);
    chk("t6_served", 128'(g), 128'(1));
    chk("t6_toggles", 128'(n_tog - n0), 128'(2));

`ifdef XBAR_SCHED_TIMEOUT_EN
    // T5: xbar never answers; watchdog returns an error response, then grants stay blocked.
    begin
      int lat;
      xb_en = 1'b0;
      req_valid = 4'b1000;
      wait_grant(g, ok);
      chk("t5_grant", 128'(g), 128'(pick(m_rr, req_valid)));
      lat = 0;
      ok  = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        lat++;
        if (rsp_valid) begin
          ok = 1'b1;
          break;
        end
      end
      chk("t5_rsp_seen", 128'(ok), 128'(1));
      chk("t5_latency", 128'(lat), 128'(TMO + 1));
      chk("t5_err", 128'(rsp_err), 128'(1));
      chk("t5_vec", 128'(rsp_vec), 128'(0));
      chk("t5_id", 128'(rsp_id), 128'(3));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      for (int t = 0; t < 30; t++) begin
        #1;
        chk("t5_blocked", 128'(req_ready), 128'(0));
        @(negedge clk);
      end
      req_valid = '0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
